// File: rtl/freq_repeat_finder_pkg.sv
// Shared types, default parameters and sum-to-bitmap index mapping for the
// repeated running-sum finder.
package freq_pkg;

    localparam int unsigned N_ENTRIES_DEF  = 973;
    localparam int unsigned ADDR_W_DEF     = 16;
    localparam int unsigned DATA_W_DEF     = 64;
    localparam int unsigned SUM_W_DEF      = 64;
    localparam int unsigned SEEN_AW_DEF    = 18;
    localparam longint      OFFSET_DEF     = 131072;
    localparam int unsigned MAX_PASSES_DEF = 1023;
    localparam int unsigned IDX_MAX_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    typedef struct packed {
        logic                 in_range;
        logic [IDX_MAX_W-1:0] idx;
    } idx_map_t;

    // Biases a sum into the bitmap; aw is the bitmap address width (<= IDX_MAX_W).
    function automatic idx_map_t sum_to_idx(input logic signed [63:0] sum,
                                            input longint offset,
                                            input int unsigned aw);
        logic signed [65:0] biased;
        idx_map_t           r;
        biased     = 66'(sum) + 66'(offset);
        r.idx      = biased[IDX_MAX_W-1:0];
        r.in_range = (biased >= 66'sd0) && (biased < (66'sd1 <<< aw));
        return r;
    endfunction

endpackage

// File: rtl/freq_repeat_finder_if.sv
// Change-list ROM bus: address out from the finder, combinational data back.
interface freq_repeat_finder_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 64
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/seen_bitmap.sv
// One-bit-per-sum seen set: combinational read, synchronous write, shared index.
module seen_bitmap #(
    parameter int unsigned DEPTH_AW = 18
) (
    input  logic                clk,
    input  logic [DEPTH_AW-1:0] idx,
    input  logic                we,
    input  logic                wr_bit,
    output logic                rd_bit
);
    logic mem [0:(1 << DEPTH_AW) - 1];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wr_bit;
    end

    assign rd_bit = mem[idx];
endmodule

// File: rtl/freq_repeat_finder.sv
// Replays a signed change list until a running sum repeats; reports the
// single-pass total and the first repeated sum.
module freq_repeat_finder
    import freq_pkg::*;
#(
    parameter int unsigned N_ENTRIES  = N_ENTRIES_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned SUM_W      = SUM_W_DEF,
    parameter int unsigned SEEN_AW    = SEEN_AW_DEF,
    parameter longint      OFFSET     = OFFSET_DEF,
    parameter int unsigned MAX_PASSES = MAX_PASSES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    freq_repeat_finder_if.master    rom,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic signed [SUM_W-1:0] pass_total,
    output logic                    pass_total_vld,
    output logic signed [SUM_W-1:0] repeat_sum,
    output logic [15:0]             passes
);
    state_e                  state_q, state_d;
    logic signed [SUM_W-1:0] sum_q, sum_d, pt_q, pt_d, rep_q, rep_d, nsum;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [15:0]             passes_q, passes_d;
    logic                    ptv_q, ptv_d, last;
    logic [SEEN_AW-1:0]      clr_q, clr_d, bm_idx;
    logic                    bm_we, bm_wbit, bm_rbit;
    idx_map_t                map;
    logic                    unused_idx_hi;

    seen_bitmap #(.DEPTH_AW(SEEN_AW)) u_seen (
        .clk    (clk),
        .idx    (bm_idx),
        .we     (bm_we),
        .wr_bit (bm_wbit),
        .rd_bit (bm_rbit)
    );

    assign unused_idx_hi = ^map.idx[IDX_MAX_W-1:SEEN_AW];

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        addr_d   = addr_q;
        passes_d = passes_q;
        pt_d     = pt_q;
        ptv_d    = ptv_q;
        rep_d    = rep_q;
        clr_d    = clr_q;
        bm_idx   = clr_q;
        bm_we    = 1'b0;
        bm_wbit  = 1'b0;
        nsum     = sum_q + SUM_W'($signed(rom.rom_data));
        map      = sum_to_idx(64'(nsum), OFFSET, SEEN_AW);
        last     = (addr_q == ADDR_W'(N_ENTRIES - 1));
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    clr_d   = '0;
                end
            end
            ST_CLEAR: begin
                // Sum 0 is pre-marked during the sweep itself: every index is
                // written exactly once, so this equals setting it at the end.
                bm_we   = 1'b1;
                bm_wbit = (64'(clr_q) == 64'(OFFSET));
                clr_d   = clr_q + 1'b1;
                if (clr_q == '1) begin
                    state_d  = ST_RUN;
                    sum_d    = '0;
                    addr_d   = '0;
                    passes_d = '0;
                    ptv_d    = 1'b0;
                end
            end
            ST_RUN: begin
                bm_idx = map.idx[SEEN_AW-1:0];
                addr_d = last ? '0 : addr_q + 1'b1;
                if (!map.in_range) begin
                    state_d = ST_ERR;
                end else begin
                    sum_d = nsum;
                    if (bm_rbit) begin
                        rep_d   = nsum;
                        state_d = ST_DONE;
                    end else begin
                        bm_we   = 1'b1;
                        bm_wbit = 1'b1;
                    end
                    if (last) begin
                        passes_d = passes_q + 16'd1;
                        if (!ptv_q) begin
                            pt_d  = nsum;
                            ptv_d = 1'b1;
                        end
                        if (!bm_rbit && passes_d == 16'(MAX_PASSES)) state_d = ST_ERR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sum_q    <= '0;
            addr_q   <= '0;
            passes_q <= '0;
            pt_q     <= '0;
            ptv_q    <= 1'b0;
            rep_q    <= '0;
            clr_q    <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            addr_q   <= addr_d;
            passes_q <= passes_d;
            pt_q     <= pt_d;
            ptv_q    <= ptv_d;
            rep_q    <= rep_d;
            clr_q    <= clr_d;
        end
    end

    assign rom.rom_addr   = addr_q;
    assign busy           = (state_q == ST_CLEAR) || (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign error          = (state_q == ST_ERR);
    assign pass_total     = pt_q;
    assign pass_total_vld = ptv_q;
    assign repeat_sum     = rep_q;
    assign passes         = passes_q;
endmodule

// File: tb/tb_freq_repeat_finder.sv
// Directed bench for freq_repeat_finder: five small configurations, each with
// its own change-list ROM and hand-computed expected results.
module tb_freq_repeat_finder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic               st1 = 1'b0, st2 = 1'b0, st3 = 1'b0, st4 = 1'b0, st5 = 1'b0;
    logic               busy1, busy2, busy3, busy4, busy5;
    logic               done1, done2, done3, done4, done5;
    logic               err1, err2, err3, err4, err5;
    logic               ptv1, ptv2, ptv3, ptv4, ptv5;
    logic signed [31:0] pt1, pt2, pt3, pt4, pt5;
    logic signed [31:0] rep1, rep2, rep3, rep4, rep5;
    logic [15:0]        pas1, pas2, pas3, pas4, pas5;
    logic signed [7:0]  rom1 [256];
    logic signed [7:0]  rom2 [256];
    logic signed [7:0]  rom3 [256];
    logic signed [7:0]  rom4 [256];
    logic signed [7:0]  rom5 [256];

    freq_repeat_finder_if #(.ADDR_W(8), .DATA_W(8)) rif1 ();
    freq_repeat_finder_if #(.ADDR_W(8), .DATA_W(8)) rif2 ();
    freq_repeat_finder_if #(.ADDR_W(8), .DATA_W(8)) rif3 ();
    freq_repeat_finder_if #(.ADDR_W(8), .DATA_W(8)) rif4 ();
    freq_repeat_finder_if #(.ADDR_W(8), .DATA_W(8)) rif5 ();

    assign rif1.rom_data = rom1[rif1.rom_addr];
    assign rif2.rom_data = rom2[rif2.rom_addr];
    assign rif3.rom_data = rom3[rif3.rom_addr];
    assign rif4.rom_data = rom4[rif4.rom_addr];
    assign rif5.rom_data = rom5[rif5.rom_addr];

    freq_repeat_finder #(.N_ENTRIES(4), .ADDR_W(8), .DATA_W(8), .SUM_W(32), .SEEN_AW(6),
                         .OFFSET(16), .MAX_PASSES(1023)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .rom(rif1.master), .busy(busy1), .done(done1),
        .error(err1), .pass_total(pt1), .pass_total_vld(ptv1), .repeat_sum(rep1), .passes(pas1));
    freq_repeat_finder #(.N_ENTRIES(2), .ADDR_W(8), .DATA_W(8), .SUM_W(32), .SEEN_AW(6),
                         .OFFSET(16), .MAX_PASSES(1023)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .rom(rif2.master), .busy(busy2), .done(done2),
        .error(err2), .pass_total(pt2), .pass_total_vld(ptv2), .repeat_sum(rep2), .passes(pas2));
    freq_repeat_finder #(.N_ENTRIES(1), .ADDR_W(8), .DATA_W(8), .SUM_W(32), .SEEN_AW(4),
                         .OFFSET(8), .MAX_PASSES(1023)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .rom(rif3.master), .busy(busy3), .done(done3),
        .error(err3), .pass_total(pt3), .pass_total_vld(ptv3), .repeat_sum(rep3), .passes(pas3));
    freq_repeat_finder #(.N_ENTRIES(2), .ADDR_W(8), .DATA_W(8), .SUM_W(32), .SEEN_AW(6),
                         .OFFSET(16), .MAX_PASSES(3)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .rom(rif4.master), .busy(busy4), .done(done4),
        .error(err4), .pass_total(pt4), .pass_total_vld(ptv4), .repeat_sum(rep4), .passes(pas4));
    freq_repeat_finder #(.N_ENTRIES(5), .ADDR_W(8), .DATA_W(8), .SUM_W(32), .SEEN_AW(6),
                         .OFFSET(16), .MAX_PASSES(1023)) u5 (
        .clk(clk), .rst_n(rst_n), .start(st5), .rom(rif5.master), .busy(busy5), .done(done5),
        .error(err5), .pass_total(pt5), .pass_total_vld(ptv5), .repeat_sum(rep5), .passes(pas5));

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start is sampled on the single posedge between the two negedges.
    task automatic pulse(input int k);
        @(negedge clk);
        case (k)
            1: st1 = 1'b1;
            2: st2 = 1'b1;
            3: st3 = 1'b1;
            4: st4 = 1'b1;
            default: st5 = 1'b1;
        endcase
        @(negedge clk);
        st1 = 1'b0; st2 = 1'b0; st3 = 1'b0; st4 = 1'b0; st5 = 1'b0;
    endtask

    task automatic test_reset;
        wait_cyc(2);
        total++; if (busy1 !== 1'b0 || done1 !== 1'b0 || err1 !== 1'b0) begin bad++; $display("FAIL rst_flags1 act=%b%b%b exp=000", busy1, done1, err1); end
        total++; if (ptv1 !== 1'b0 || pt1 !== 0 || rep1 !== 0) begin bad++; $display("FAIL rst_results1 act=%b/%0d/%0d exp=0/0/0", ptv1, pt1, rep1); end
        total++; if (pas1 !== 16'd0 || rif1.rom_addr !== 8'd0) begin bad++; $display("FAIL rst_cnt1 act=%0d/%0d exp=0/0", pas1, rif1.rom_addr); end
        rst_n = 1'b1;
        wait_cyc(2);
        total++; if (busy4 !== 1'b0 || done4 !== 1'b0 || err4 !== 1'b0) begin bad++; $display("FAIL idle_flags4 act=%b%b%b exp=000", busy4, done4, err4); end
    endtask

    task automatic test_basic;
        pulse(1);
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL basic_busy act=%b exp=1", busy1); end
        wait_cyc(64 + 3);
        total++; if (ptv1 !== 1'b0) begin bad++; $display("FAIL basic_vld_early act=%b exp=0", ptv1); end
        total++; if (rif1.rom_addr !== 8'd3) begin bad++; $display("FAIL basic_addr act=%0d exp=3", rif1.rom_addr); end
        wait_cyc(1);
        total++; if (ptv1 !== 1'b1 || pt1 !== 3) begin bad++; $display("FAIL basic_pass_total act=%b/%0d exp=1/3", ptv1, pt1); end
        total++; if (rif1.rom_addr !== 8'd0) begin bad++; $display("FAIL basic_addr_wrap act=%0d exp=0", rif1.rom_addr); end
        wait_cyc(1);
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL basic_done_early act=%b exp=0", done1); end
        wait_cyc(1);
        total++; if (done1 !== 1'b1 || busy1 !== 1'b0 || err1 !== 1'b0) begin bad++; $display("FAIL basic_done act=%b%b%b exp=100", done1, busy1, err1); end
        total++; if (rep1 !== 2 || pas1 !== 16'd1) begin bad++; $display("FAIL basic_repeat act=%0d/%0d exp=2/1", rep1, pas1); end
        wait_cyc(3);
        total++; if (done1 !== 1'b1 || rep1 !== 2) begin bad++; $display("FAIL basic_hold act=%b/%0d exp=1/2", done1, rep1); end
    endtask

    task automatic test_busy_start;
        pulse(1);
        total++; if (done1 !== 1'b0 || busy1 !== 1'b1) begin bad++; $display("FAIL restart_state act=%b%b exp=01", done1, busy1); end
        total++; if (ptv1 !== 1'b1 || pt1 !== 3 || rep1 !== 2) begin bad++; $display("FAIL restart_prev_visible act=%b/%0d/%0d exp=1/3/2", ptv1, pt1, rep1); end
        wait_cyc(10);
        pulse(1);
        wait_cyc(64 + 6 - 12 - 1);
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL busy_start_done_early act=%b exp=0", done1); end
        wait_cyc(1);
        total++; if (done1 !== 1'b1 || rep1 !== 2 || pt1 !== 3) begin bad++; $display("FAIL busy_start_result act=%b/%0d/%0d exp=1/2/3", done1, rep1, pt1); end
    endtask

    task automatic test_five;
        rom5[0] = 8'sd3; rom5[1] = 8'sd3; rom5[2] = 8'sd4; rom5[3] = -8'sd2; rom5[4] = -8'sd4;
        pulse(5);
        wait_cyc(64 + 5);
        total++; if (ptv5 !== 1'b1 || pt5 !== 4 || done5 !== 1'b0) begin bad++; $display("FAIL five_a_pass act=%b/%0d/%b exp=1/4/0", ptv5, pt5, done5); end
        wait_cyc(2);
        total++; if (done5 !== 1'b1 || rep5 !== 10 || pas5 !== 16'd1) begin bad++; $display("FAIL five_a_repeat act=%b/%0d/%0d exp=1/10/1", done5, rep5, pas5); end
        rom5[0] = -8'sd6; rom5[1] = 8'sd3; rom5[2] = 8'sd8; rom5[3] = 8'sd5; rom5[4] = -8'sd6;
        pulse(5);
        wait_cyc(64 + 11);
        total++; if (done5 !== 1'b0 || pas5 !== 16'd2) begin bad++; $display("FAIL five_b_pre act=%b/%0d exp=0/2", done5, pas5); end
        wait_cyc(1);
        total++; if (done5 !== 1'b1 || rep5 !== 5 || pt5 !== 4) begin bad++; $display("FAIL five_b_repeat act=%b/%0d/%0d exp=1/5/4", done5, rep5, pt5); end
    endtask

    task automatic test_zero_repeat;
        rom2[0] = 8'sd1; rom2[1] = -8'sd1;
        pulse(2);
        wait_cyc(64 + 1);
        total++; if (ptv2 !== 1'b0 || done2 !== 1'b0) begin bad++; $display("FAIL zero_pre act=%b%b exp=00", ptv2, done2); end
        wait_cyc(1);
        total++; if (done2 !== 1'b1 || rep2 !== 0) begin bad++; $display("FAIL zero_repeat act=%b/%0d exp=1/0", done2, rep2); end
        total++; if (ptv2 !== 1'b1 || pt2 !== 0 || pas2 !== 16'd1) begin bad++; $display("FAIL zero_same_cycle act=%b/%0d/%0d exp=1/0/1", ptv2, pt2, pas2); end
    endtask

    task automatic test_out_of_range;
        rom3[0] = 8'sd1;
        pulse(3);
        wait_cyc(16 + 7);
        total++; if (err3 !== 1'b0 || pas3 !== 16'd7) begin bad++; $display("FAIL oor_pre act=%b/%0d exp=0/7", err3, pas3); end
        wait_cyc(1);
        total++; if (err3 !== 1'b1 || done3 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL oor_error act=%b%b%b exp=100", err3, done3, busy3); end
        total++; if (u3.sum_q !== 7 || pas3 !== 16'd7 || pt3 !== 1) begin bad++; $display("FAIL oor_hold act=%0d/%0d/%0d exp=7/7/1", u3.sum_q, pas3, pt3); end
    endtask

    task automatic test_max_passes;
        rom4[0] = 8'sd5; rom4[1] = 8'sd5;
        pulse(4);
        wait_cyc(64 + 5);
        total++; if (err4 !== 1'b0 || pas4 !== 16'd2) begin bad++; $display("FAIL maxp_pre act=%b/%0d exp=0/2", err4, pas4); end
        wait_cyc(1);
        total++; if (err4 !== 1'b1 || done4 !== 1'b0 || pas4 !== 16'd3) begin bad++; $display("FAIL maxp_error act=%b/%b/%0d exp=1/0/3", err4, done4, pas4); end
        total++; if (pt4 !== 10 || ptv4 !== 1'b1) begin bad++; $display("FAIL maxp_total act=%0d/%b exp=10/1", pt4, ptv4); end
    endtask

    task automatic test_reset_midrun;
        pulse(1);
        wait_cyc(66);
        rst_n = 1'b0;
        #1;
        total++; if (busy1 !== 1'b0 || done1 !== 1'b0 || err1 !== 1'b0) begin bad++; $display("FAIL midrst_flags act=%b%b%b exp=000", busy1, done1, err1); end
        total++; if (ptv1 !== 1'b0 || pt1 !== 0 || rep1 !== 0 || pas1 !== 16'd0 || rif1.rom_addr !== 8'd0) begin
            bad++; $display("FAIL midrst_outputs act=%b/%0d/%0d/%0d/%0d exp=0/0/0/0/0", ptv1, pt1, rep1, pas1, rif1.rom_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse(1);
        wait_cyc(64 + 1);
        total++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin bad++; $display("FAIL midrst_no_stale act=%b%b exp=10", busy1, done1); end
        wait_cyc(3);
        total++; if (ptv1 !== 1'b1 || pt1 !== 3) begin bad++; $display("FAIL midrst_pass_total act=%b/%0d exp=1/3", ptv1, pt1); end
        wait_cyc(2);
        total++; if (done1 !== 1'b1 || rep1 !== 2 || pas1 !== 16'd1) begin bad++; $display("FAIL midrst_repeat act=%b/%0d/%0d exp=1/2/1", done1, rep1, pas1); end
    endtask

    initial begin
        rom1[0] = 8'sd1; rom1[1] = -8'sd2; rom1[2] = 8'sd3; rom1[3] = 8'sd1;
        rom2[0] = 8'sd0; rom3[0] = 8'sd0; rom4[0] = 8'sd0; rom5[0] = 8'sd0;
        test_reset;
        test_basic;
        test_busy_start;
        test_five;
        test_zero_repeat;
        test_out_of_range;
        test_max_passes;
        test_reset_midrun;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
